// File: rtl/instr_mem_sequencer.sv
// Multi-cycle fetch/decode/data/commit sequencer that shares one single-port memory
// between instruction fetch and load/store access, with a request watchdog.
module instr_mem_sequencer #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           TIMEOUT    = 16,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] instr,
  input  logic                  dreq_valid,
  input  logic                  dreq_we,
  input  logic [DATA_WIDTH-1:0] dreq_addr,
  input  logic [DATA_WIDTH-1:0] dreq_wdata,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  commit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  bus_err
);

  localparam int unsigned CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned CNT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_DATA,
    S_COMMIT,
    S_ERR
  } state_e;

  state_e                  state_q,   state_d;
  logic [DATA_WIDTH-1:0]   instr_q,   instr_d;
  logic [DATA_WIDTH-1:0]   drdata_q,  drdata_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic                    commit_q,  commit_d;
  logic                    bus_err_q, bus_err_d;
  logic                    timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(CNT_LAST));

  // Memory-side request; rst abandons any access in the very cycle it is high.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = PC;
      end
      S_DATA: begin
        mem_req   = 1'b1;
        mem_we    = dreq_we;
        mem_addr  = dreq_addr;
        mem_wdata = dreq_wdata;
      end
      default: ;
    endcase
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d  = state_q;
    instr_d  = instr_q;
    drdata_d = drdata_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_FETCH, S_DATA: begin
        if (mem_ack) begin
          cnt_d = '0;
          if (state_q == S_FETCH) begin
            instr_d = mem_rdata;
            state_d = S_DECODE;
          end else begin
            if (!dreq_we) drdata_d = mem_rdata;
            state_d = S_COMMIT;
          end
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        cnt_d   = '0;
        state_d = dreq_valid ? S_DATA : S_COMMIT;
      end
      S_COMMIT: begin
        cnt_d   = '0;
        state_d = S_FETCH;
      end
      default: ;
    endcase
    commit_d  = (state_d == S_COMMIT);
    bus_err_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q   <= S_FETCH;
      instr_q   <= NOP_INSTR;
      drdata_q  <= '0;
      cnt_q     <= '0;
      commit_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      drdata_q  <= drdata_d;
      cnt_q     <= cnt_d;
      commit_q  <= commit_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign instr   = instr_q;
  assign drdata  = drdata_q;
  assign commit  = commit_q;
  assign bus_err = bus_err_q;

endmodule

// File: doc/instr_mem_sequencer.md
Name: instr_mem_sequencer

Overview:
- Multi-cycle sequencer that shares one single-port unified memory between instruction fetch and load/store data access in the RV32I core.
- Fetches the instruction at PC and holds it stable for decode. It then performs the optional data access and emits a one-cycle commit pulse.
- The commit pulse gates PC update and register-file write.
- A watchdog flags a memory that never acknowledges.

Parameters:
- DATA_WIDTH, 32, width of address, data and instruction buses.
- TIMEOUT, 16, max cycles a memory request may wait for mem_ack (0 = watchdog disabled).
- NOP_INSTR, 32'h00000013, value held on instr after reset (addi x0,x0,0).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- PC  in  DATA_WIDTH  current program counter (stable until commit).
- instr  out  DATA_WIDTH  latched instruction fed to decode/regfile/extend.
- dreq_valid  in  1  decoded instruction needs data memory (load or store).
- dreq_we  in  1  1 = store, 0 = load; valid with dreq_valid.
- dreq_addr  in  DATA_WIDTH  data address (ALUResult).
- dreq_wdata  in  DATA_WIDTH  store data.
- drdata  out  DATA_WIDTH  latched load data for the write-back mux.
- commit  out  1  one-cycle pulse: advance PC, permit RegWrite.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  DATA_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ack  in  1  memory done; mem_rdata is valid in this cycle.
- mem_rdata  in  DATA_WIDTH  memory read data.
- bus_err  out  1  sticky watchdog error.

Behaviour:
- States: FETCH, DECODE, DATA, COMMIT, ERR. Registered state; reset state is FETCH.
- Reset values:
  - instr = NOP_INSTR, drdata = 0, commit = 0, bus_err = 0, watchdog count = 0.
  - mem_req = 0 in every cycle rst is high; mem_req is combinationally gated by rst.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_addr=PC, mem_wdata=0.
  - On mem_ack: instr <= mem_rdata, then go to DECODE. Without ack, stay in FETCH.
- DECODE:
  - mem_req=0 for exactly 1 cycle, so the decode logic settles on the new instr.
  - Samples dreq_valid: 1 goes to DATA, 0 goes to COMMIT.
- DATA:
  - Drives mem_req=1, mem_we=dreq_we, mem_addr=dreq_addr, mem_wdata=dreq_wdata.
  - On mem_ack: if dreq_we=0, drdata <= mem_rdata; then go to COMMIT.
  - The dreq_* inputs must be stable through DATA. They are, because instr and the regfile are frozen until commit.
- COMMIT:
  - commit=1 for exactly 1 cycle, mem_req=0, then go to FETCH.
  - commit is high only in COMMIT.
- Latency:
  - Ack may arrive in the same cycle as the request (zero wait).
  - Minimum 3 cycles per non-memory instruction (FETCH, DECODE, COMMIT).
  - Minimum 4 cycles per load/store.
  - Each wait cycle adds 1.
- Holding behaviour:
  - instr holds its value outside FETCH-with-ack.
  - drdata holds until the next load ack; stores do not change it.
- mem_ack while mem_req=0 (DECODE/COMMIT/ERR) is ignored.
- Watchdog (TIMEOUT>0):
  - The counter clears on entry to FETCH/DATA and on each ack.
  - It increments each cycle in FETCH/DATA with mem_ack=0.
  - An ack in the cycle where count==TIMEOUT-1 is still accepted.
  - count==TIMEOUT-1 with no ack goes to ERR. So a request is allowed TIMEOUT cycles in total.
- ERR:
  - mem_req=0, commit=0, bus_err=1.
  - ERR is left only by rst.
- Reset mid-access: the request is abandoned immediately (mem_req=0 in the rst cycle). Next cycle is FETCH with a fresh request at the current PC.
- The counter width is $clog2(TIMEOUT+1) with a minimum of 1 bit. There is no wrap, because the counter saturates into ERR.

Test Plan:
- Zero-wait ALU instr: mem acks same cycle, PC=0x0, mem_rdata=0x00500093.
  - Required: instr=0x00500093 after the FETCH edge; commit high exactly in cycle 3; next mem_req addr=PC in cycle 4.
- Load, 2 wait states on both accesses: dreq_valid=1, dreq_we=0, dreq_addr=0x100, mem_rdata=0xDEADBEEF at ack.
  - Required: drdata=0xDEADBEEF; commit in cycle 8; mem_we=0 throughout.
- Store: dreq_we=1, addr=0x104, wdata=0x12345678, zero wait.
  - Required: during DATA, mem_we=1, mem_addr=0x104, mem_wdata=0x12345678; drdata unchanged; commit at cycle 4.
- Watchdog, TIMEOUT=4:
  - Ack never asserted in FETCH: bus_err=1 after 4 request cycles, mem_req=0 and no commit thereafter. A later rst clears bus_err and restarts FETCH.
  - Ack on the 4th request cycle: accepted, no error.
- Reset mid-DATA with ack pending: mem_req drops in the rst cycle; instr=0x00000013; drdata=0; the first post-reset request is a fetch (mem_we=0, addr=PC).
- Spurious mem_ack in DECODE and COMMIT: no state change, instr/drdata unchanged, commit still exactly one cycle.
